// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: RV32I EX slice. Main control decode, ALU-control decode and
// the ALU, all outputs registered (one-cycle latency).
// Optional feature: define ALU_SHIFT_EN to build the shifter (SLL/SRL/SRA).
// Without it, shift encodings are reported as illegal and produce a safe NOP.
module alu_ctrl_exec #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  output logic [7:0]        ctrl,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

  localparam int SHW = $clog2(DATA_W);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  // Decoded stage contents, written into the output registers as one unit.
  typedef struct packed {
    logic [7:0]        ctrl;
    logic [3:0]        op;
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              ill;
  } exec_t;

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic              i30;
  logic [7:0]        ctrl_d;
  logic [1:0]        aluop;
  logic              bad_op, bad_fn, is_shift, ill_d;
  logic [3:0]        op_d;
  logic [DATA_W-1:0] b_sel, res_d;
  logic [SHW-1:0]    shamt;
  exec_t             ex_d;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign i30    = instr[30];

  // Only opcode, funct3 and bit 30 matter to this slice.
  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Main control: opcode -> {ALUSrc,MemtoReg,MemRead,MemWrite,Branch,RegWrite,ALUOp}
  always_comb begin
    ctrl_d = 8'h00;
    bad_op = 1'b0;
    case (opcode)
      7'b0110011: ctrl_d = 8'b0000_0110;  // R-type
      7'b0010011: ctrl_d = 8'b1000_0111;  // I-ALU
      7'b0000011: ctrl_d = 8'b1110_0100;  // load
      7'b0100011: ctrl_d = 8'b1001_0000;  // store
      7'b1100011: ctrl_d = 8'b0000_1001;  // beq
      default:    bad_op = 1'b1;
    endcase
  end

  assign aluop = ctrl_d[1:0];

  // ALU control: ALUOp/funct3/bit30 -> 4-bit op. ALUOp 11 (I-ALU) ignores
  // bit30 except to pick SRA, since it belongs to the immediate there.
  always_comb begin
    op_d     = OP_ADD;
    bad_fn   = 1'b0;
    is_shift = 1'b0;
    case (aluop)
      2'b00: op_d = OP_ADD;
      2'b01: op_d = OP_SUB;
      default: begin
        case (f3)
          3'b000: op_d = (aluop == 2'b10 && i30) ? OP_SUB : OP_ADD;
          3'b111: op_d = OP_AND;
          3'b110: op_d = OP_OR;
          3'b100: op_d = OP_XOR;
          3'b001: begin op_d = OP_SLL; is_shift = 1'b1; end
          3'b101: begin op_d = i30 ? OP_SRA : OP_SRL; is_shift = 1'b1; end
          3'b010: op_d = OP_SLT;
          default: op_d = OP_SLTU;
        endcase
        if (aluop == 2'b10 && i30 && f3 != 3'b000 && f3 != 3'b101) begin
          bad_fn = 1'b1;
          op_d   = OP_ADD;
        end
      end
    endcase
  end

  assign ill_d = bad_op | bad_fn | (is_shift & ~SHIFT_EN);
  assign b_sel = ctrl_d[7] ? imm : op_b;
  assign shamt = b_sel[SHW-1:0];

  // ALU datapath; an illegal instruction is forced to a zero result.
  always_comb begin
    res_d = '0;
    case (op_d)
      OP_AND:  res_d = op_a & b_sel;
      OP_OR:   res_d = op_a | b_sel;
      OP_ADD:  res_d = op_a + b_sel;
      OP_XOR:  res_d = op_a ^ b_sel;
      OP_SUB:  res_d = op_a - b_sel;
      OP_SLT:  res_d = DATA_W'($signed(op_a) < $signed(b_sel));
      OP_SLTU: res_d = DATA_W'(op_a < b_sel);
`ifdef ALU_SHIFT_EN
      OP_SLL:  res_d = op_a << shamt;
      OP_SRL:  res_d = op_a >> shamt;
      OP_SRA:  res_d = $unsigned($signed(op_a) >>> shamt);
`else
`endif
      default: res_d = '0;
    endcase
    if (ill_d) res_d = '0;
  end

`ifndef ALU_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  assign ex_d.ctrl = ill_d ? 8'h00 : ctrl_d;
  assign ex_d.op   = op_d;
  assign ex_d.res  = res_d;
  assign ex_d.zero = (res_d == '0);
  assign ex_d.ill  = ill_d;

  // Output registers: reset wins, an idle cycle registers an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || !in_valid) begin
      out_valid <= 1'b0;
      ctrl      <= '0;
      alu_ctrl  <= '0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b1;
      ctrl      <= ex_d.ctrl;
      alu_ctrl  <= ex_d.op;
      result    <= ex_d.res;
      zero      <= ex_d.zero;
      illegal   <= ex_d.ill;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// tb_alu_ctrl_exec: directed vectors with hand-computed expectations.
// Shift expectations follow ALU_SHIFT_EN, matching the build of the design.
module tb_alu_ctrl_exec;

  localparam logic [6:0] R_T = 7'b0110011;
  localparam logic [6:0] I_T = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [31:0] instr, op_a, op_b, imm;
  logic        out_valid;
  logic [7:0]  ctrl;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero, illegal;

  int n_chk = 0;
  int n_err = 0;

  alu_ctrl_exec #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .op_a(op_a), .op_b(op_b), .imm(imm),
    .out_valid(out_valid), .ctrl(ctrl), .alu_ctrl(alu_ctrl),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic i30);
    mk = {1'b0, i30, 15'h0, f3, 5'h0, opc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Apply one instruction, step one edge, sample 1 time unit later.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic v);
    instr = ins; op_a = a; op_b = b; imm = im; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_all(input string t, input logic ov, input logic [7:0] c,
                         input logic chk_op, input logic [3:0] op,
                         input logic [31:0] r, input logic z, input logic il);
    chk({t, ".valid"}, 32'(out_valid), 32'(ov));
    chk({t, ".ctrl"},  32'(ctrl), 32'(c));
    if (chk_op) chk({t, ".alu"}, 32'(alu_ctrl), 32'(op));
    chk({t, ".res"},   result, r);
    chk({t, ".zero"},  32'(zero), 32'(z));
    chk({t, ".ill"},   32'(illegal), 32'(il));
  endtask

  initial begin
    rst = 1'b1;
    // Reset held two cycles with in_valid high: everything stays zero.
    issue(mk(R_T, 3'b000, 1'b0), 32'd5, 32'd3, 32'd0, 1'b1);
    issue(mk(R_T, 3'b000, 1'b0), 32'd5, 32'd3, 32'd0, 1'b1);
    exp_all("rst", 0, 8'h00, 1, 4'h0, 32'h0, 0, 0);
    rst = 1'b0;

    // R-type, op_a=5 op_b=3
    issue(mk(R_T, 3'b000, 1'b0), 32'd5, 32'd3, 32'd0, 1'b1);
    exp_all("add", 1, 8'h06, 1, 4'b0010, 32'd8, 0, 0);
    issue(mk(R_T, 3'b000, 1'b1), 32'd5, 32'd3, 32'd0, 1'b1);
    exp_all("sub", 1, 8'h06, 1, 4'b0110, 32'd2, 0, 0);
    issue(mk(R_T, 3'b111, 1'b0), 32'd5, 32'd3, 32'd0, 1'b1);
    exp_all("and", 1, 8'h06, 1, 4'b0000, 32'd1, 0, 0);
    issue(mk(R_T, 3'b110, 1'b0), 32'd5, 32'd3, 32'd0, 1'b1);
    exp_all("or", 1, 8'h06, 1, 4'b0001, 32'd7, 0, 0);
    issue(mk(R_T, 3'b100, 1'b0), 32'd5, 32'd3, 32'd0, 1'b1);
    exp_all("xor", 1, 8'h06, 1, 4'b0011, 32'd6, 0, 0);
    issue(mk(R_T, 3'b010, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    exp_all("slt", 1, 8'h06, 1, 4'b0111, 32'd1, 0, 0);
    issue(mk(R_T, 3'b011, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    exp_all("sltu", 1, 8'h06, 1, 4'b1001, 32'd0, 1, 0);
    // bit30 set with funct3 AND: illegal, safe NOP, op forced to ADD
    issue(mk(R_T, 3'b111, 1'b1), 32'd5, 32'd3, 32'd0, 1'b1);
    exp_all("r_ill", 1, 8'h00, 1, 4'b0010, 32'd0, 1, 1);

    // Load/store use imm, not op_b
    issue(mk(LD, 3'b010, 1'b0), 32'h100, 32'h55, 32'hFFFF_FFFC, 1'b1);
    exp_all("lw", 1, 8'hE4, 1, 4'b0010, 32'hFC, 0, 0);
    issue(mk(ST, 3'b010, 1'b0), 32'h100, 32'h55, 32'hFFFF_FFFC, 1'b1);
    exp_all("sw", 1, 8'h90, 1, 4'b0010, 32'hFC, 0, 0);

    // beq uses op_b
    issue(mk(BR, 3'b000, 1'b0), 32'h1234, 32'h1234, 32'h8, 1'b1);
    exp_all("beq_eq", 1, 8'h09, 1, 4'b0110, 32'h0, 1, 0);
    issue(mk(BR, 3'b000, 1'b0), 32'h1234, 32'h1000, 32'h8, 1'b1);
    exp_all("beq_ne", 1, 8'h09, 1, 4'b0110, 32'h234, 0, 0);

    // I-ALU: bit30 does not turn addi into sub
    issue(mk(I_T, 3'b000, 1'b1), 32'd10, 32'd99, 32'd5, 1'b1);
    exp_all("addi", 1, 8'h87, 1, 4'b0010, 32'd15, 0, 0);
    issue(mk(I_T, 3'b010, 1'b0), 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1);
    exp_all("slti", 1, 8'h87, 1, 4'b0111, 32'd1, 0, 0);

    // Shifts
`ifdef ALU_SHIFT_EN
    issue(mk(I_T, 3'b101, 1'b1), 32'h8000_0000, 32'd0, 32'd4, 1'b1);
    exp_all("srai", 1, 8'h87, 1, 4'b1000, 32'hF800_0000, 0, 0);
    issue(mk(I_T, 3'b101, 1'b0), 32'h8000_0000, 32'd0, 32'd4, 1'b1);
    exp_all("srli", 1, 8'h87, 1, 4'b0101, 32'h0800_0000, 0, 0);
    issue(mk(I_T, 3'b001, 1'b0), 32'd1, 32'd0, 32'd33, 1'b1);
    exp_all("slli", 1, 8'h87, 1, 4'b0100, 32'd2, 0, 0);
    issue(mk(R_T, 3'b101, 1'b1), 32'h8000_0000, 32'd36, 32'd0, 1'b1);
    exp_all("sra", 1, 8'h06, 1, 4'b1000, 32'hF800_0000, 0, 0);
`else
    issue(mk(I_T, 3'b101, 1'b1), 32'h8000_0000, 32'd0, 32'd4, 1'b1);
    exp_all("srai", 1, 8'h00, 0, 4'h0, 32'h0, 1, 1);
    issue(mk(I_T, 3'b101, 1'b0), 32'h8000_0000, 32'd0, 32'd4, 1'b1);
    exp_all("srli", 1, 8'h00, 0, 4'h0, 32'h0, 1, 1);
    issue(mk(I_T, 3'b001, 1'b0), 32'd1, 32'd0, 32'd33, 1'b1);
    exp_all("slli", 1, 8'h00, 0, 4'h0, 32'h0, 1, 1);
    issue(mk(R_T, 3'b101, 1'b1), 32'h8000_0000, 32'd36, 32'd0, 1'b1);
    exp_all("sra", 1, 8'h00, 0, 4'h0, 32'h0, 1, 1);
`endif

    // Bubble between ops
    issue(mk(R_T, 3'b000, 1'b0), 32'd5, 32'd3, 32'd0, 1'b0);
    exp_all("bubble", 0, 8'h00, 1, 4'h0, 32'h0, 0, 0);

    // Illegal opcode
    issue(32'h0000_007F, 32'd5, 32'd3, 32'd7, 1'b1);
    exp_all("bad_opc", 1, 8'h00, 0, 4'h0, 32'h0, 1, 1);

    // Back-to-back after illegal, then reset priority over in_valid
    issue(mk(R_T, 3'b000, 1'b1), 32'd9, 32'd9, 32'd0, 1'b1);
    exp_all("sub_zero", 1, 8'h06, 1, 4'b0110, 32'h0, 1, 0);
    rst = 1'b1;
    issue(mk(R_T, 3'b000, 1'b0), 32'd5, 32'd3, 32'd0, 1'b1);
    exp_all("rst_pri", 0, 8'h00, 1, 4'h0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
